control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the phase-1 DataPath. It drives the one-hot register select lines, the bus-out and register-in strobes, the ALU operation code and the memory-read handshake. This sequences fetch, decode and execute for register ALU, immediate, multiply/divide, unary, nop and halt instructions, replacing the hand-timed stimulus that drives DataPath today. An instruction counter and a per-instruction retire pulse support bring-up and verification.

## Interface
Parameters:
- RESET_PC_UNUSED, none: no parameters; every width is fixed by the DataPath (16 registers, 32-bit bus, 5-bit ALU code).

Ports:
- clock  in  1  system clock; all state changes on rising edge
- clear  in  1  synchronous, active-high reset
- run  in  1  leave IDLE and start fetching when 1
- ir  in  32  DataPath IR contents; op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15]
- mem_ready  in  1  memory data valid on Mdata this cycle
- regIn, regOut  out  16  one-hot register load / drive selects
- HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, IRIn, MARIn  out  1 each  register load strobes
- HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, COut  out  1 each  bus drive strobes; COut drives sign-extended ir[18:0]
- IncPC  out  1  PC increment
- MDRread, mem_read  out  1 each  MDR source select = memory / memory read request
- ALUcode  out  5  ALU operation
- retire  out  1  one-cycle pulse on instruction completion
- illegal  out  1  one-cycle pulse on undefined opcode
- halted  out  1  high while in HALT
- instr_count  out  16  retired-instruction count

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs are decoded combinationally from the state and ir. Every output not listed for a state is 0.
- IDLE: stay until run=1, then T0.
- T0: PCOut, MARIn, IncPC. Next T1.
- T1: mem_read, MDRread, MDRIn. Hold T1 while mem_ready=0. Go to T2 when mem_ready=1.
- T2: MDROut, IRIn. Next T3. ir is valid from T3 onward.
- T3 decode:
  - R-ALU (op 00011..01011: add, sub, shr, shra, shl, ror, rol, and, or), immediate (01100 addi, 01101 andi, 01110 ori) and mul/div (01111 mul, 10000 div): regOut[Rb], YIn, then T4.
  - Unary (10001 neg, 10010 not): no strobes, then T4.
  - 11010 nop: retire, then T0.
  - 11011 halt: retire, then HALT.
  - Any other opcode: illegal and retire, then T0.
- T4: ZIn; ALUcode=op. The operand source depends on class:
  - R-ALU and mul/div: regOut[Rc].
  - Immediate: COut.
  - Unary: regOut[Rb].
  - Next T5.
- T5:
  - mul/div: ZLoOut, LoIn, then T6.
  - All other classes: ZLoOut, regIn[Ra], retire, then T0.
- T6 (mul/div only): ZHiOut, HiIn, retire. Next T0.
- HALT: halted=1. Stay until clear; run is ignored.
- ALUcode=op only in T4; it is 5'b00000 in every other state.
- regIn and regOut are at most one-hot. They are all-zero outside the states above.
- instr_count increments by 1 on every cycle with retire=1 and wraps 16'hFFFF to 0. illegal, nop and halt each count as retired.

## Timing
- clear=1 at a rising edge forces IDLE and instr_count=0, regardless of state, run or mem_ready.
- Reset values: all strobes, selects, ALUcode, retire, illegal and halted are 0 while in IDLE.
- clear takes priority mid-instruction, including in T1 wait and HALT. No partially sequenced strobes occur after the clearing edge.
- Latency from T0 entry to retire, with mem_ready=1 in the first T1 cycle:
  - nop, halt, illegal: 4 cycles.
  - R-ALU, immediate, unary: 6 cycles.
  - mul/div: 7 cycles.
  - Each T1 wait cycle adds 1.
- After retire, T0 of the next instruction follows on the next cycle; there are no bubbles.
- run=0 after leaving IDLE has no effect; the controller free-runs until halt or clear.

## Test plan
- R-ALU: R3=0xE3, R7=4, ir={01011,0100,0011,0111,...}, mem_ready=1. Required: T3 regOut=0x0008+YIn; T4 regOut=0x0080, ZIn, ALUcode=01011; T5 ZLoOut, regIn=0x0010, retire; instr_count=1.
- Memory wait: hold mem_ready=0 for 3 cycles in T1. Required: MDRIn/mem_read held 4 cycles, IRIn exactly one cycle later, total R-ALU latency 9.
- mul: op 01111, Ra=0, Rb=2, Rc=5. Required: T4 regOut=0x0020; T5 LoIn+ZLoOut; T6 HiIn+ZHiOut+retire; regIn stays 0 throughout.
- Immediate and unary: for addi, COut in T4 and regOut=0. For not (10010) with Rb=9, no YIn in T3 and regOut=0x0200 in T4.
- Halt and illegal: op 11111 gives illegal+retire in T3, then T0. Op 11011 gives halted=1 held for 10 cycles with run toggling; instr_count=2.
- Clear mid-T4 of an R-ALU instruction. Required: next cycle IDLE with all outputs 0 and instr_count=0. With run=1, T0 follows on the next cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute controller for the phase-1 DataPath.
// Strobes are decoded combinationally from the state register and the IR opcode.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] regIn,
  output logic [15:0] regOut,
  output logic        HiIn,
  output logic        LoIn,
  output logic        ZIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        YIn,
  output logic        IRIn,
  output logic        MARIn,
  output logic        HiOut,
  output logic        LoOut,
  output logic        ZHiOut,
  output logic        ZLoOut,
  output logic        PCOut,
  output logic        MDROut,
  output logic        COut,
  output logic        IncPC,
  output logic        MDRread,
  output logic        mem_read,
  output logic [4:0]  ALUcode,
  output logic        retire,
  output logic        illegal,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_count;
  logic [4:0]  w_op;
  logic [3:0]  w_ra, w_rb, w_rc;
  logic        w_ralu, w_imm, w_muldiv, w_unary, w_nop, w_halt;
  logic        w_unused_ir_bits;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

  assign w_op   = ir[31:27];
  assign w_ra   = ir[26:23];
  assign w_rb   = ir[22:19];
  assign w_rc   = ir[18:15];
  assign w_unused_ir_bits = ^ir[14:0];

  assign w_ralu   = (w_op >= 5'd3) && (w_op <= 5'd11);
  assign w_imm    = (w_op >= 5'd12) && (w_op <= 5'd14);
  assign w_muldiv = (w_op == 5'd15) || (w_op == 5'd16);
  assign w_unary  = (w_op == 5'd17) || (w_op == 5'd18);
  assign w_nop    = (w_op == 5'd26);
  assign w_halt   = (w_op == 5'd27);

  assign instr_count = r_count;

  // State register and retired-instruction counter; clear overrides everything.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_count <= 16'd0;
    end else begin
      r_state <= w_next;
      if (retire) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_next   = r_state;
    regIn    = 16'd0;
    regOut   = 16'd0;
    HiIn     = 1'b0;
    LoIn     = 1'b0;
    ZIn      = 1'b0;
    PCIn     = 1'b0;
    MDRIn    = 1'b0;
    YIn      = 1'b0;
    IRIn     = 1'b0;
    MARIn    = 1'b0;
    HiOut    = 1'b0;
    LoOut    = 1'b0;
    ZHiOut   = 1'b0;
    ZLoOut   = 1'b0;
    PCOut    = 1'b0;
    MDROut   = 1'b0;
    COut     = 1'b0;
    IncPC    = 1'b0;
    MDRread  = 1'b0;
    mem_read = 1'b0;
    ALUcode  = 5'd0;
    retire   = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_T0;
        else     w_next = S_IDLE;
      end
      S_T0: begin
        PCOut  = 1'b1;
        MARIn  = 1'b1;
        IncPC  = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        mem_read = 1'b1;
        MDRread  = 1'b1;
        MDRIn    = 1'b1;
        if (mem_ready) w_next = S_T2;
        else           w_next = S_T1;
      end
      S_T2: begin
        MDROut = 1'b1;
        IRIn   = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        if (w_ralu || w_imm || w_muldiv) begin
          regOut = onehot16(w_rb);
          YIn    = 1'b1;
          w_next = S_T4;
        end else if (w_unary) begin
          w_next = S_T4;
        end else if (w_nop) begin
          retire = 1'b1;
          w_next = S_T0;
        end else if (w_halt) begin
          retire = 1'b1;
          w_next = S_HALT;
        end else begin
          illegal = 1'b1;
          retire  = 1'b1;
          w_next  = S_T0;
        end
      end
      S_T4: begin
        ZIn     = 1'b1;
        ALUcode = w_op;
        // Second operand: immediate field, Rb for unary ops, Rc otherwise.
        if (w_imm)        COut   = 1'b1;
        else if (w_unary) regOut = onehot16(w_rb);
        else              regOut = onehot16(w_rc);
        w_next = S_T5;
      end
      S_T5: begin
        ZLoOut = 1'b1;
        if (w_muldiv) begin
          LoIn   = 1'b1;
          w_next = S_T6;
        end else begin
          regIn  = onehot16(w_ra);
          retire = 1'b1;
          w_next = S_T0;
        end
      end
      S_T6: begin
        ZHiOut = 1'b1;
        HiIn   = 1'b1;
        retire = 1'b1;
        w_next = S_T0;
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction expected strobe traces
// are queued at issue time and compared by a monitor when the DUT retires.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  logic [15:0] regIn, regOut, instr_count;
  logic        HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, IRIn, MARIn;
  logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, COut;
  logic        IncPC, MDRread, mem_read, retire, illegal, halted;
  logic [4:0]  ALUcode;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .regIn(regIn), .regOut(regOut),
    .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn), .YIn(YIn),
    .IRIn(IRIn), .MARIn(MARIn),
    .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut), .PCOut(PCOut),
    .MDROut(MDROut), .COut(COut), .IncPC(IncPC), .MDRread(MDRread), .mem_read(mem_read),
    .ALUcode(ALUcode), .retire(retire), .illegal(illegal), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] regIn;
    logic [15:0] regOut;
    logic HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, IRIn, MARIn;
    logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, COut;
    logic IncPC, MDRread, mem_read;
    logic [4:0] alu;
    logic retire, illegal, halted;
  } outv_t;

  outv_t obs;
  assign obs = {regIn, regOut, HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, IRIn, MARIn,
                HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, COut,
                IncPC, MDRread, mem_read, ALUcode, retire, illegal, halted};

  int          n_total = 0;
  int          n_pass  = 0;
  outv_t       exp_vec_q[$];
  int          exp_len_q[$];
  logic [15:0] exp_cnt_q[$];
  bit          exp_halt_q[$];
  logic [15:0] model_count = 16'd0;
  int          cur_wait = 0;
  int          wait_left = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic logic [15:0] sel(input logic [3:0] n);
    logic [15:0] v;
    v = 16'd0;
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    logic [14:0] lo;
    lo = 15'($urandom);
    return {op, ra, rb, rc, lo};
  endfunction

  // Reference model: the strobe sequence an instruction must produce from T0 to retire.
  task automatic push_instr(input logic [31:0] instr, input int waits);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    outv_t v;
    int len;
    op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
    len = 0;
    v = '0; v.PCOut = 1'b1; v.MARIn = 1'b1; v.IncPC = 1'b1;
    exp_vec_q.push_back(v); len++;
    for (int i = 0; i <= waits; i++) begin
      v = '0; v.mem_read = 1'b1; v.MDRread = 1'b1; v.MDRIn = 1'b1;
      exp_vec_q.push_back(v); len++;
    end
    v = '0; v.MDROut = 1'b1; v.IRIn = 1'b1;
    exp_vec_q.push_back(v); len++;
    if (op >= 5'd3 && op <= 5'd16) begin
      v = '0; v.regOut = sel(rb); v.YIn = 1'b1;
      exp_vec_q.push_back(v); len++;
      v = '0; v.ZIn = 1'b1; v.alu = op;
      if (op >= 5'd12 && op <= 5'd14) v.COut = 1'b1;
      else v.regOut = sel(rc);
      exp_vec_q.push_back(v); len++;
      if (op >= 5'd15) begin
        v = '0; v.ZLoOut = 1'b1; v.LoIn = 1'b1;
        exp_vec_q.push_back(v); len++;
        v = '0; v.ZHiOut = 1'b1; v.HiIn = 1'b1; v.retire = 1'b1;
        exp_vec_q.push_back(v); len++;
      end else begin
        v = '0; v.ZLoOut = 1'b1; v.regIn = sel(ra); v.retire = 1'b1;
        exp_vec_q.push_back(v); len++;
      end
    end else if (op == 5'd17 || op == 5'd18) begin
      v = '0;
      exp_vec_q.push_back(v); len++;
      v = '0; v.ZIn = 1'b1; v.alu = op; v.regOut = sel(rb);
      exp_vec_q.push_back(v); len++;
      v = '0; v.ZLoOut = 1'b1; v.regIn = sel(ra); v.retire = 1'b1;
      exp_vec_q.push_back(v); len++;
    end else begin
      v = '0; v.retire = 1'b1;
      if (op != 5'd26 && op != 5'd27) v.illegal = 1'b1;
      exp_vec_q.push_back(v); len++;
    end
    model_count = model_count + 16'd1;
    exp_len_q.push_back(len);
    exp_cnt_q.push_back(model_count);
    exp_halt_q.push_back(op == 5'd27);
  endtask

  // Memory model: stalls the read for the requested number of T1 cycles.
  always @(negedge clock) begin
    if (PCOut) wait_left = cur_wait;
    if (mem_read) begin
      mem_ready = (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end else begin
      mem_ready = 1'($urandom);
    end
  end

  // Monitor: records the trace since T0 and scores it at every retire.
  outv_t       trace[$];
  bit          tracing = 1'b0;
  bit          pend = 1'b0;
  logic [15:0] pend_cnt;
  bit          pend_halt;
  always @(negedge clock) begin
    if (mon_en) begin
      if (pend) begin
        pend = 1'b0;
        check("count_after_retire", 64'(instr_count), 64'(pend_cnt));
        if (pend_halt) check("halted_after_halt", 64'(halted), 64'd1);
        else           check("t0_after_retire", 64'(PCOut), 64'd1);
      end
      if (PCOut) begin
        trace.delete();
        tracing = 1'b1;
      end
      if (tracing) trace.push_back(obs);
      if (retire) begin
        tracing = 1'b0;
        if (exp_len_q.size() == 0) begin
          check("scoreboard_underflow", 64'd1, 64'd0);
        end else begin
          int len, bad;
          outv_t e, bad_e, bad_a;
          len = exp_len_q.pop_front();
          pend_cnt = exp_cnt_q.pop_front();
          pend_halt = exp_halt_q.pop_front();
          pend = 1'b1;
          bad = -1;
          bad_e = '0; bad_a = '0;
          for (int i = 0; i < len; i++) begin
            e = exp_vec_q.pop_front();
            if (bad < 0 && i < trace.size() && trace[i] !== e) begin
              bad = i; bad_e = e; bad_a = trace[i];
            end
          end
          check("trace_length", 64'(trace.size()), 64'(len));
          if (bad >= 0) $display("FAIL trace_cycle_%0d: got %h, expected %h", bad, bad_a, bad_e);
          n_total++;
          if (bad < 0) n_pass++;
        end
      end
    end
  end

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  task automatic wait_retire();
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (retire) return;
    end
    check("retire_timeout", 64'd0, 64'd1);
    finish_run();
  endtask

  task automatic issue(input logic [31:0] instr, input int waits);
    ir = instr;
    cur_wait = waits;
    push_instr(instr, waits);
    wait_retire();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit found;
    clear = 1'b1; run = 1'b0; ir = 32'd0; mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    mon_en = 1'b1;
    check("reset_outputs", 64'(obs), 64'd0);
    check("reset_count", 64'(instr_count), 64'd0);
    clear = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_hold_outputs", 64'(obs), 64'd0);

    run = 1'b1;
    issue(mk(5'd11, 4'd4, 4'd3, 4'd7), 0);
    issue(mk(5'd3, 4'd1, 4'd2, 4'd3), 3);
    issue(mk(5'd15, 4'd0, 4'd2, 4'd5), 0);
    issue(mk(5'd16, 4'd6, 4'd1, 4'd14), 1);
    issue(mk(5'd12, 4'd2, 4'd8, 4'd0), 0);
    issue(mk(5'd18, 4'd5, 4'd9, 4'd0), 2);
    issue(mk(5'd17, 4'd15, 4'd0, 4'd3), 0);
    issue(mk(5'd31, 4'd1, 4'd1, 4'd1), 0);
    issue(mk(5'd26, 4'd0, 4'd0, 4'd0), 1);
    for (int k = 0; k < 60; k++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run = 1'($urandom);
      issue(mk(op, 4'($urandom), 4'($urandom), 4'($urandom)), int'($urandom_range(0, 3)));
    end
    issue(mk(5'd27, 4'd0, 4'd0, 4'd0), 0);

    for (int k = 0; k < 10; k++) begin
      run = 1'($urandom);
      @(negedge clock);
      check("halt_held", 64'({halted, PCOut, retire}), 64'b100);
    end
    check("halt_count", 64'(instr_count), 64'(model_count));

    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_count = 16'd0;
    check("clear_halt_outputs", 64'(obs), 64'd0);
    check("clear_halt_count", 64'(instr_count), 64'd0);

    ir = mk(5'd5, 4'd3, 4'd4, 4'd5);
    cur_wait = int'($urandom_range(0, 2));
    run = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clock);
      if (ZIn) found = 1'b1;
    end
    check("reach_t4", 64'(found), 64'd1);
    clear = 1'b1;
    @(negedge clock);
    check("clear_t4_outputs", 64'(obs), 64'd0);
    check("clear_t4_count", 64'(instr_count), 64'd0);
    clear = 1'b0;
    ir = mk(5'd9, 4'd7, 4'd6, 4'd2);
    cur_wait = 1;
    push_instr(ir, 1);
    @(negedge clock);
    check("clear_restart_t0", 64'(PCOut), 64'd1);
    wait_retire();
    repeat (2) @(negedge clock);
    finish_run();
  end

endmodule
